alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width; all values below assume 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; only the flags register uses it.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port op, input, 3 bits: operation select.
REQ-005 SHALL have port lhs, input, 16 bits, signed: left operand.
REQ-006 SHALL have port rhs, input, 16 bits, signed: right operand.
REQ-007 SHALL have port result, output, 16 bits, signed: operation result.
REQ-008 SHALL have port flags, output, 5 bits: registered status bits {div0, ovf, carry, neg, zero}, with zero at bit 0.

Function
REQ-009 SHALL compute result combinationally from op, lhs and rhs with zero clock latency; it is valid after delta-cycle settling, with no clock edge required.
REQ-010 SHALL decode op as follows:
- 0 ADD
- 1 SUB (lhs-rhs)
- 2 MUL (low 16 bits of the signed product)
- 3 DIV (signed quotient)
- 4 AND
- 5 OR
- 6 XOR
- 7 SHL (lhs shifted left logically by rhs[3:0])
REQ-011 SHALL truncate DIV toward zero, so sign(quotient) = sign(lhs) XOR sign(rhs); examples: 29/2=14, 2/29=0, -7/2=-3, 7/-2=-3.
REQ-012 SHALL return 16'hFFFF from DIV when rhs=0 and assert next-state div0; no X/Z may appear on result.
REQ-013 SHALL return -32768 from DIV of -32768 by -1 and assert next-state ovf.
REQ-014 SHALL set next-state ovf for ADD/SUB on signed overflow and for MUL when the full 32-bit product does not fit in 16 signed bits; ovf SHALL be 0 for the other ops.
REQ-015 SHALL set next-state carry to the unsigned carry-out for ADD and to the borrow (lhs<rhs unsigned) for SUB; carry SHALL be 0 for the other ops.
REQ-016 SHALL set next-state zero to (result==0) and next-state neg to result[15], for every op.
REQ-017 SHALL load flags from the next-state values on every rising edge of clk while rst is low.
REQ-018 SHALL keep result independent of flags; there is no feedback path.

Reset
REQ-019 SHALL clear flags to 5'b00000 immediately when rst is asserted, asynchronously to clk.
REQ-020 SHALL leave result unaffected by rst; it remains a purely combinational function of its inputs.
REQ-021 SHALL let the first clk edge after rst deasserts load flags normally.

Structure
REQ-022 SHALL take the op enum (ADD..SHL), the WIDTH default and the flag bit indices from shared package alu_pkg.
REQ-023 SHALL implement DIV in a sub-module alu_divider: a combinational 16-stage restoring divider on magnitudes, with sign fixup, div-by-zero and overflow detect. The divider SHALL NOT be implemented with a synthesis "/" operator.
REQ-024 SHALL keep all remaining ops in the alu top, inside one combinational case block plus one flags always block.

Verification
REQ-025 SHALL cover this sweep: op=3, lhs and rhs each 2..29 -> result = floor(lhs/rhs) for all 784 pairs (e.g. 29/2=14, 7/3=2, 2/29=0).
REQ-026 SHALL cover: op=3, lhs=-7, rhs=2 -> result=-3; lhs=-32768, rhs=-1 -> result=-32768, and ovf=1 after the next clk edge.
REQ-027 SHALL cover: op=3, lhs=5, rhs=0 -> result=16'hFFFF, and flags=5'b10010 after the clk edge (div0=1, neg=1).
REQ-028 SHALL cover: op=0, lhs=32767, rhs=1 -> result=-32768, with ovf=1 and neg=1 after the edge; op=1, lhs=3, rhs=3 -> result=0, zero=1, carry=0.
REQ-029 SHALL cover: op=2, lhs=300, rhs=300 -> result=16'h5F90, ovf=1; op=7, lhs=1, rhs=15 -> result=16'h8000.
REQ-030 SHALL cover: assert rst between clk edges while flags is nonzero -> flags=0 immediately, and result still tracks its inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encoding, default width and flag bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHL = 3'd7
  } alu_op_e;

  localparam int FLAG_W     = 5;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_DIV0  = 4;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed divider: restoring long division on magnitudes, quotient truncated
// toward zero, with divide-by-zero and most-negative-by-minus-one detection.
module alu_divider import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic signed [WIDTH-1:0] num,
  input  logic signed [WIDTH-1:0] den,
  output logic signed [WIDTH-1:0] quot,
  output logic                    div0,
  output logic                    ovf
);

  logic [WIDTH-1:0] nmag;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] qmag;
  logic [WIDTH:0]   rem;
  logic             qneg;

  // The most negative value negates to itself, which is still its correct unsigned magnitude.
  assign nmag = num[WIDTH-1] ? unsigned'(-num) : unsigned'(num);
  assign dmag = den[WIDTH-1] ? unsigned'(-den) : unsigned'(den);
  assign qneg = num[WIDTH-1] ^ den[WIDTH-1];

  always_comb begin
    rem  = '0;
    qmag = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], nmag[i]};
      if (rem >= {1'b0, dmag}) begin
        rem     = rem - {1'b0, dmag};
        qmag[i] = 1'b1;
      end
    end
  end

  assign div0 = (den == '0);
  assign ovf  = (num == {1'b1, {(WIDTH-1){1'b0}}}) && (den == '1);

  always_comb begin
    if (div0)
      quot = '1;
    else if (qneg)
      quot = -$signed(qmag);
    else
      quot = $signed(qmag);
  end

endmodule

// File: rtl/alu.sv
// Combinational ALU with a registered status flags word {div0, ovf, carry, neg, zero}.
module alu import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              op,
  input  logic signed [WIDTH-1:0] lhs,
  input  logic signed [WIDTH-1:0] rhs,
  output logic signed [WIDTH-1:0] result,
  output logic [FLAG_W-1:0]       flags
);

  logic [WIDTH:0]             add_ext;
  logic [WIDTH:0]             sub_ext;
  logic signed [2*WIDTH-1:0]  prod;
  logic signed [WIDTH-1:0]    div_q;
  logic                       div_zero;
  logic                       div_ovf;
  logic                       ovf_nxt;
  logic                       carry_nxt;
  logic                       div0_nxt;
  logic [FLAG_W-1:0]          flags_nxt;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .num  (lhs),
    .den  (rhs),
    .quot (div_q),
    .div0 (div_zero),
    .ovf  (div_ovf)
  );

  assign add_ext = {1'b0, lhs} + {1'b0, rhs};
  assign sub_ext = {1'b0, lhs} - {1'b0, rhs};
  assign prod    = $signed({{WIDTH{lhs[WIDTH-1]}}, lhs}) * $signed({{WIDTH{rhs[WIDTH-1]}}, rhs});

  always_comb begin
    result    = '0;
    ovf_nxt   = 1'b0;
    carry_nxt = 1'b0;
    div0_nxt  = 1'b0;
    unique case (alu_op_e'(op))
      OP_ADD: begin
        result    = $signed(add_ext[WIDTH-1:0]);
        carry_nxt = add_ext[WIDTH];
        ovf_nxt   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (add_ext[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_SUB: begin
        result    = $signed(sub_ext[WIDTH-1:0]);
        carry_nxt = sub_ext[WIDTH];
        ovf_nxt   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (sub_ext[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_MUL: begin
        result  = prod[WIDTH-1:0];
        // Product fits only if the upper half plus the result sign bit are all copies of the sign.
        ovf_nxt = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
      end
      OP_DIV: begin
        result   = div_q;
        ovf_nxt  = div_ovf;
        div0_nxt = div_zero;
      end
      OP_AND: result = lhs & rhs;
      OP_OR:  result = lhs | rhs;
      OP_XOR: result = lhs ^ rhs;
      OP_SHL: result = lhs << rhs[3:0];
      default: result = '0;
    endcase
  end

  always_comb begin
    flags_nxt             = '0;
    flags_nxt[FLAG_ZERO]  = (result == '0);
    flags_nxt[FLAG_NEG]   = result[WIDTH-1];
    flags_nxt[FLAG_CARRY] = carry_nxt;
    flags_nxt[FLAG_OVF]   = ovf_nxt;
    flags_nxt[FLAG_DIV0]  = div0_nxt;
  end

  // Flags register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else
      flags <= flags_nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: combinational results, registered flags, async reset, DIV sweep.
module tb_alu;

  logic               clk;
  logic               rst;
  logic [2:0]         op;
  logic signed [15:0] lhs;
  logic signed [15:0] rhs;
  logic signed [15:0] result;
  logic [4:0]         flags;

  int vectors;
  int miscompares;

  alu #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .lhs    (lhs),
    .rhs    (rhs),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs, check the combinational result, then check flags after the next edge.
  task automatic step(input string tag, input logic [2:0] o, input logic [15:0] l,
                      input logic [15:0] r, input logic [15:0] exp_res, input logic [4:0] exp_flg);
    op  = o;
    lhs = l;
    rhs = r;
    #1;
    check({tag, "_result"}, result, exp_res);
    @(posedge clk);
    #1;
    check({tag, "_flags"}, {11'd0, flags}, {11'd0, exp_flg});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    op  = 3'd0;
    lhs = 16'sd0;
    rhs = 16'sd0;
    #2;
    check("reset_flags", {11'd0, flags}, 16'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    step("add_ovf",     3'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010);
    step("add_carry",   3'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101);
    step("sub_zero",    3'd1, 16'h0003, 16'h0003, 16'h0000, 5'b00001);
    step("mul_ovf",     3'd2, 16'd300,  16'd300,  16'h5F90, 5'b01000);
    step("shl_15",      3'd7, 16'h0001, 16'h000F, 16'h8000, 5'b00010);
    step("and",         3'd4, 16'h0F0F, 16'h00FF, 16'h000F, 5'b00000);
    step("or",          3'd5, 16'hF000, 16'h000F, 16'hF00F, 5'b00010);
    step("xor",         3'd6, 16'hAAAA, 16'hFFFF, 16'h5555, 5'b00000);
    step("div_m7_2",    3'd3, 16'hFFF9, 16'h0002, 16'hFFFD, 5'b00010);
    step("div_7_m2",    3'd3, 16'h0007, 16'hFFFE, 16'hFFFD, 5'b00010);
    step("div_min_m1",  3'd3, 16'h8000, 16'hFFFF, 16'h8000, 5'b01010);
    step("div_by_zero", 3'd3, 16'h0005, 16'h0000, 16'hFFFF, 5'b10010);

    // Asynchronous reset between edges while flags hold 5'b10010.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_flags", {11'd0, flags}, 16'd0);
    op  = 3'd1;
    lhs = 16'sd1;
    rhs = 16'sd2;
    #1;
    check("rst_result_tracks", result, 16'hFFFF);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_after_rst", {11'd0, flags}, {11'd0, 5'b00110});

    op = 3'd3;
    for (int a = 2; a <= 29; a++) begin
      for (int b = 2; b <= 29; b++) begin
        lhs = 16'(a);
        rhs = 16'(b);
        #1;
        check($sformatf("div_%0d_%0d", a, b), result, 16'(a / b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
